// File: rtl/branch_ctrl_if.sv
// Pipeline-facing signal bundle of the EX-stage branch resolution controller.
// The master side is the core pipeline; the slave side is branch_ctrl.
interface branch_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] if_pc;
    logic                  pred_taken;
    logic                  ex_valid;
    logic                  ex_stall;
    logic                  ex_is_branch;
    logic                  ex_is_jal;
    logic                  ex_is_jalr;
    logic [DATA_WIDTH-1:0] ex_pc;
    logic [DATA_WIDTH-1:0] ex_imm;
    logic [DATA_WIDTH-1:0] ex_rs1;
    logic                  ex_pred_taken;
    logic                  branch_result;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  flush;
    logic                  busy;
    logic [31:0]           mispredict_count;

    modport master (
        output if_pc, ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_pc, ex_imm, ex_rs1, ex_pred_taken, branch_result,
        input  pred_taken, redirect_valid, redirect_pc, flush, busy, mispredict_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_pc, ex_imm, ex_rs1, ex_pred_taken, branch_result,
        output pred_taken, redirect_valid, redirect_pc, flush, busy, mispredict_count
    );
endinterface

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: 2-bit direction table, misprediction detection,
// registered PC redirect and multi-cycle IF/ID flush.
//
// state | meaning
// IDLE  | resolving EX instructions, no redirect outstanding
// FLUSH | redirect issued, squashing wrong-path IF/ID for FLUSH_CYCLES cycles
module branch_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input logic           clk,
    input logic           rst_n,
    branch_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0]      if_idx, ex_idx;
    logic [1:0]            bht_cur, bht_next;
    logic                  bht_we;
    logic                  is_jump, resolve, mispredict, take_redirect;
    logic [DATA_WIDTH-1:0] target_pc, jalr_sum, jalr_target, fall_pc, corr_pc;
    logic                  redirect_valid_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;
    logic [31:0]           count_q;
    logic                  unused_if_pc;

    assign if_idx       = bus.if_pc[IDX_W+1:2];
    assign ex_idx       = bus.ex_pc[IDX_W+1:2];
    assign unused_if_pc = ^{bus.if_pc[DATA_WIDTH-1:IDX_W+2], bus.if_pc[1:0]};

    assign is_jump     = bus.ex_is_jal | bus.ex_is_jalr;
    assign resolve     = bus.ex_valid & ~bus.ex_stall & (state_q == IDLE);
    assign target_pc   = bus.ex_pc + bus.ex_imm;
    assign jalr_sum    = bus.ex_rs1 + bus.ex_imm;
    assign jalr_target = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
    assign fall_pc     = bus.ex_pc + DATA_WIDTH'(4);

    // Jumps take priority over a simultaneously flagged conditional branch.
    always_comb begin
        mispredict = 1'b0;
        corr_pc    = fall_pc;
        if (is_jump) begin
            mispredict = 1'b1;
            corr_pc    = bus.ex_is_jalr ? jalr_target : target_pc;
        end else if (bus.ex_is_branch) begin
            mispredict = (bus.branch_result != bus.ex_pred_taken);
            corr_pc    = bus.branch_result ? target_pc : fall_pc;
        end
    end

    assign bht_we = resolve & bus.ex_is_branch & ~is_jump;

    always_comb begin
        bht_cur  = bht_q[ex_idx];
        bht_next = bht_cur;
        if (bus.branch_result) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'd1;
        end else begin
            if (bht_cur != 2'b00) bht_next = bht_cur - 2'd1;
        end
    end

    // Writes land at the edge, so a same-cycle IF read sees the old counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else if (bht_we) begin
            bht_q[ex_idx] <= bht_next;
        end
    end

    assign bus.pred_taken = bht_q[if_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        take_redirect = 1'b0;
        case (state_q)
            IDLE: begin
                if (resolve && mispredict) begin
                    take_redirect = 1'b1;
                    state_d       = FLUSH;
                    cnt_d         = CNT_INIT;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            count_q          <= '0;
        end else begin
            redirect_valid_q <= take_redirect;
            if (take_redirect) begin
                redirect_pc_q <= corr_pc;
                count_q       <= count_q + 32'd1;
            end
        end
    end

    assign bus.redirect_valid   = redirect_valid_q;
    assign bus.redirect_pc      = redirect_pc_q;
    assign bus.flush            = (state_q == FLUSH);
    assign bus.busy             = (state_q == FLUSH);
    assign bus.mispredict_count = count_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the controller.
module tb_branch_ctrl;
    localparam int DW  = 32;
    localparam int NB  = 16;
    localparam int NFL = 2;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    branch_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    branch_ctrl #(.DATA_WIDTH(DW), .BHT_ENTRIES(NB), .FLUSH_CYCLES(NFL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model state
    int          m_bht [NB];
    int          m_flush_left;
    bit          m_rv;
    logic [31:0] m_rpc;
    logic [31:0] m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % NB);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) m_bht[i] = 1;
        m_flush_left = 0;
        m_rv         = 0;
        m_rpc        = '0;
        m_count      = '0;
    endtask

    task automatic set_idle();
        bus.ex_valid      = 0;
        bus.ex_stall      = 0;
        bus.ex_is_branch  = 0;
        bus.ex_is_jal     = 0;
        bus.ex_is_jalr    = 0;
        bus.ex_pc         = '0;
        bus.ex_imm        = '0;
        bus.ex_rs1        = '0;
        bus.ex_pred_taken = 0;
        bus.branch_result = 0;
    endtask

    task automatic drive(input bit v, input bit st, input bit br, input bit jal, input bit jalr,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                         input bit pred, input bit res);
        bus.ex_valid      = v;
        bus.ex_stall      = st;
        bus.ex_is_branch  = br;
        bus.ex_is_jal     = jal;
        bus.ex_is_jalr    = jalr;
        bus.ex_pc         = pc;
        bus.ex_imm        = imm;
        bus.ex_rs1        = rs1;
        bus.ex_pred_taken = pred;
        bus.branch_result = res;
    endtask

    // Check outputs against the model, step the model with the current inputs,
    // and advance to just after the next rising edge.
    task automatic cycle();
        int          n_flush;
        bit          n_rv;
        logic [31:0] n_rpc, n_count, corr;
        bit          mis, upd;
        int          ui, uval;
        @(negedge clk);
        check("pred_taken", bus.pred_taken, (m_bht[idx_of(bus.if_pc)] >= 2) ? 1 : 0);
        check("redirect_valid", bus.redirect_valid, m_rv);
        check("redirect_pc", bus.redirect_pc, m_rpc);
        check("flush", bus.flush, (m_flush_left > 0) ? 1 : 0);
        check("busy", bus.busy, (m_flush_left > 0) ? 1 : 0);
        check("mispredict_count", bus.mispredict_count, m_count);
        n_flush = m_flush_left;
        n_rv    = 0;
        n_rpc   = m_rpc;
        n_count = m_count;
        upd     = 0;
        ui      = 0;
        uval    = 0;
        mis     = 0;
        corr    = '0;
        if (m_flush_left > 0) begin
            n_flush = m_flush_left - 1;
        end else if (bus.ex_valid && !bus.ex_stall) begin
            if (bus.ex_is_jal || bus.ex_is_jalr) begin
                mis  = 1;
                corr = bus.ex_is_jalr ? ((bus.ex_rs1 + bus.ex_imm) & 32'hFFFF_FFFE)
                                      : (bus.ex_pc + bus.ex_imm);
            end else if (bus.ex_is_branch) begin
                mis  = (bus.branch_result != bus.ex_pred_taken);
                corr = bus.branch_result ? (bus.ex_pc + bus.ex_imm) : (bus.ex_pc + 32'd4);
                upd  = 1;
                ui   = idx_of(bus.ex_pc);
                uval = bus.branch_result ? ((m_bht[ui] < 3) ? m_bht[ui] + 1 : 3)
                                         : ((m_bht[ui] > 0) ? m_bht[ui] - 1 : 0);
            end
            if (mis) begin
                n_flush = NFL;
                n_rv    = 1;
                n_rpc   = corr;
                n_count = m_count + 32'd1;
            end
        end
        @(posedge clk);
        m_flush_left = n_flush;
        m_rv         = n_rv;
        m_rpc        = n_rpc;
        m_count      = n_count;
        if (upd) m_bht[ui] = uval;
        #1;
    endtask

    initial begin
        int k;
        rst_n = 0;
        set_idle();
        bus.if_pc = 32'h40;
        model_reset();
        #1;
        check("rst_pred", bus.pred_taken, 0);
        check("rst_rv", bus.redirect_valid, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_count", bus.mispredict_count, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rpc", bus.redirect_pc, 0);
        rst_n = 1;
        repeat (2) cycle();

        // taken branch predicted not-taken
        drive(1, 0, 1, 0, 0, 32'h100, 32'h20, 32'h0, 0, 1);
        cycle();
        set_idle();
        bus.if_pc = 32'h100;
        #1;
        check("br_taken_rv", bus.redirect_valid, 1);
        check("br_taken_rpc", bus.redirect_pc, 32'h120);
        check("br_taken_cnt", bus.mispredict_count, 1);
        check("br_taken_pred", bus.pred_taken, 1);
        repeat (3) cycle();

        // not-taken branch predicted taken, then saturation
        drive(1, 0, 1, 0, 0, 32'h104, 32'h40, 32'h0, 1, 0);
        cycle();
        set_idle();
        #1;
        check("br_nt_rpc", bus.redirect_pc, 32'h108);
        repeat (3) cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 0, 32'h104, 32'h40, 32'h0, 0, 0);
            cycle();
            set_idle();
            #1;
            check("br_nt_no_redirect", bus.redirect_valid, 0);
        end
        bus.if_pc = 32'h104;
        #1;
        check("br_nt_sat_pred", bus.pred_taken, 0);
        cycle();

        // JALR target bit0 cleared; wrong-path branch during flush ignored
        drive(1, 0, 0, 0, 1, 32'h300, 32'h10, 32'h2001, 0, 0);
        cycle();
        drive(1, 0, 1, 0, 0, 32'h100, 32'h20, 32'h0, 1, 0);
        #1;
        check("jalr_rpc", bus.redirect_pc, 32'h2010);
        cycle();
        cycle();
        set_idle();
        bus.if_pc = 32'h100;
        #1;
        check("flush_ignore_rv", bus.redirect_valid, 0);
        check("flush_ignore_cnt", bus.mispredict_count, 3);
        check("flush_ignore_bht", bus.pred_taken, 1);
        cycle();

        // stalled mispredicting branch
        drive(1, 1, 1, 0, 0, 32'h180, 32'h8, 32'h0, 0, 1);
        repeat (3) cycle();
        bus.ex_stall = 0;
        cycle();
        set_idle();
        #1;
        check("stall_rv", bus.redirect_valid, 1);
        check("stall_rpc", bus.redirect_pc, 32'h188);
        check("stall_cnt", bus.mispredict_count, 4);
        repeat (3) cycle();

        // reset in the first flush cycle
        drive(1, 0, 0, 1, 0, 32'h200, 32'h40, 32'h0, 0, 0);
        cycle();
        set_idle();
        rst_n = 0;
        #1;
        check("midrst_flush", bus.flush, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_rv", bus.redirect_valid, 0);
        check("midrst_cnt", bus.mispredict_count, 0);
        check("midrst_pred", bus.pred_taken, 0);
        model_reset();
        rst_n = 1;
        repeat (2) cycle();

        // counter wrap
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFF;
        drive(1, 0, 0, 1, 0, 32'h200, 32'h40, 32'h0, 0, 0);
        cycle();
        set_idle();
        #1;
        check("wrap_cnt", bus.mispredict_count, 0);
        repeat (3) cycle();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            k = $urandom_range(0, 9);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  (k <= 4) || (k == 7), (k == 5) || (k == 7), k == 6,
                  32'h1000 + 32'($urandom_range(0, 63)) * 4, $urandom, $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            bus.if_pc = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
